// File: rtl/afifo_txn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// afifo_txn_pkg : shared transaction types for the async FIFO traffic blocks
// Rev 1.1 : error kinds, write status codes and write-master FSM states
// ============================================================================
package afifo_txn_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    UNDERFLOW = 2'd1,
    OVERFLOW  = 2'd2
  } error_t;

  typedef enum logic [1:0] {
    WR_OK      = 2'd0,
    WR_TIMEOUT = 2'd1,
    WR_OVF_INJ = 2'd2
  } wr_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/afifo_wr_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// afifo_wr_master : single-outstanding write initiator for the async FIFO
// Rev 1.1 : full-stall retry with timeout, overflow injection, status return
// ============================================================================
module afifo_wr_master
  import afifo_txn_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_FULL_RETRY = 10
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_err_inject,
  input  error_t                req_err_type,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output wr_status_t            resp_status,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wfull,
  output logic                  full_evt,
  output logic                  ovf_evt,
  output logic                  timeout_evt,
  output logic [31:0]           wr_count
);

  localparam int              c_RW         = $clog2(MAX_FULL_RETRY + 1);
  localparam logic [c_RW-1:0] c_RETRY_LAST = c_RW'(MAX_FULL_RETRY - 1);

  if ((MAX_FULL_RETRY < 1) || (ADDR_WIDTH < 1)) begin : g_param_check
    $error("afifo_wr_master: MAX_FULL_RETRY and ADDR_WIDTH must be >= 1");
  end

  wr_state_t             r_state;
  wr_state_t             w_state_next;
  logic [c_RW-1:0]       r_retry_cnt;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_inj_q;
  logic                  r_full_evt;
  logic                  r_timeout_evt;
  wr_status_t            r_status;
  logic [31:0]           r_wr_count;

  logic w_accept;
  logic w_req_inj;
  logic w_full_stall;
  logic w_retry_last;

  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_req_inj    = req_err_inject && (req_err_type == OVERFLOW);
  assign w_full_stall = (r_state == CHECK) && wfull;
  assign w_retry_last = (r_retry_cnt == c_RETRY_LAST);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_req_inj ? ISSUE : CHECK;
        end
      end
      CHECK: begin
        if (!wfull) begin
          w_state_next = ISSUE;
        end else if (w_retry_last) begin
          w_state_next = RESP;
        end
      end
      ISSUE: w_state_next = RESP;
      RESP: begin
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake and write strobes decode only the state flop, so reset kills them at once.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    winc       = 1'b0;
    ovf_evt    = 1'b0;
    case (r_state)
      IDLE:  req_ready  = 1'b1;
      ISSUE: begin
        winc    = 1'b1;
        ovf_evt = r_inj_q;
      end
      RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_retry_cnt   <= '0;
      r_data_q      <= '0;
      r_wdata       <= '0;
      r_inj_q       <= 1'b0;
      r_full_evt    <= 1'b0;
      r_timeout_evt <= 1'b0;
      r_status      <= WR_OK;
      r_wr_count    <= '0;
    end else begin
      r_full_evt    <= w_full_stall;
      r_timeout_evt <= w_full_stall && w_retry_last;

      if (w_accept) begin
        r_data_q    <= req_data;
        r_inj_q     <= w_req_inj;
        r_retry_cnt <= '0;
      end else if (w_full_stall && !w_retry_last) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
      end

      if (w_full_stall && w_retry_last) begin
        r_status <= WR_TIMEOUT;
      end

      // An injected write skips CHECK, so its data comes straight from the request.
      if (w_state_next == ISSUE) begin
        r_wdata <= (r_state == IDLE) ? req_data : r_data_q;
      end

      if (r_state == ISSUE) begin
        r_wr_count <= r_wr_count + 32'd1;
        r_status   <= r_inj_q ? WR_OVF_INJ : WR_OK;
      end
    end
  end

  assign wdata       = r_wdata;
  assign resp_status = r_status;
  assign full_evt    = r_full_evt;
  assign timeout_evt = r_timeout_evt;
  assign wr_count    = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_afifo_wr_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_afifo_wr_master : directed self-checking bench for afifo_wr_master
// Rev 1.1
// ============================================================================
module tb_afifo_wr_master;
  import afifo_txn_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int MAXR = 10;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic          req_err_inject = 1'b0;
  error_t        req_err_type = ERR_NONE;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  wr_status_t    resp_status;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull = 1'b0;
  logic          full_evt;
  logic          ovf_evt;
  logic          timeout_evt;
  logic [31:0]   wr_count;

  afifo_wr_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MAX_FULL_RETRY (MAXR)
  ) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_err_inject (req_err_inject),
    .req_err_type   (req_err_type),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_status    (resp_status),
    .winc           (winc),
    .wdata          (wdata),
    .wfull          (wfull),
    .full_evt       (full_evt),
    .ovf_evt        (ovf_evt),
    .timeout_evt    (timeout_evt),
    .wr_count       (wr_count)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;

  // Pulse counters sampled on the rising edge (pre-update values).
  int          n_winc, n_full, n_ovf, n_to, full_at_to;
  logic [31:0] last_wdata;

  always @(posedge wclk) begin
    if (winc === 1'b1) begin
      n_winc++;
      last_wdata = wdata;
    end
    if (full_evt === 1'b1) n_full++;
    if (ovf_evt === 1'b1) n_ovf++;
    if (timeout_evt === 1'b1) begin
      n_to++;
      full_at_to = n_full;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_winc     = 0;
    n_full     = 0;
    n_ovf      = 0;
    n_to       = 0;
    full_at_to = 0;
    last_wdata = '0;
  endtask

  // Present one request for one accepting edge; returns on the following falling edge.
  task automatic send(input logic [DW-1:0] d, input logic inj, input error_t et);
    req_valid      = 1'b1;
    req_data       = d;
    req_err_inject = inj;
    req_err_type   = et;
    @(negedge wclk);
    req_valid      = 1'b0;
    req_err_inject = 1'b0;
    req_err_type   = ERR_NONE;
  endtask

  task automatic wait_resp(input string tag, input int max_cyc);
    int k;
    k = 0;
    while ((resp_valid !== 1'b1) && (k < max_cyc)) begin
      @(negedge wclk);
      k++;
    end
    chk(tag, resp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_mon();
    repeat (2) @(negedge wclk);

    // Reset state
    chk("rst_winc", winc, 1'b0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_status", resp_status, WR_OK);
    chk("rst_evts", {full_evt, ovf_evt, timeout_evt}, 3'b000);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_req_ready", req_ready, 1'b1);
    wrst_n = 1'b1;
    @(negedge wclk);

    // Basic write: winc two cycles after accept
    chk("t1_req_ready", req_ready, 1'b1);
    send(32'hDEADBEEF, 1'b0, ERR_NONE);
    chk("t1_check_winc", winc, 1'b0);
    @(negedge wclk);
    chk("t1_issue_winc", winc, 1'b1);
    chk("t1_issue_wdata", wdata, 32'hDEADBEEF);
    @(negedge wclk);
    chk("t1_resp_winc", winc, 1'b0);
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_status", resp_status, WR_OK);
    chk("t1_wr_count", wr_count, 32'd1);
    chk("t1_wdata_hold", wdata, 32'hDEADBEEF);
    @(negedge wclk);
    chk("t1_idle_resp_valid", resp_valid, 1'b0);
    chk("t1_idle_req_ready", req_ready, 1'b1);

    // Three full cycles, then write
    clr_mon();
    wfull = 1'b1;
    send(32'h0000_1234, 1'b0, ERR_NONE);
    repeat (3) @(negedge wclk);
    wfull = 1'b0;
    wait_resp("t2_resp", 20);
    chk("t2_status", resp_status, WR_OK);
    @(negedge wclk);
    chk("t2_full_evts", n_full, 3);
    chk("t2_winc_cnt", n_winc, 1);
    chk("t2_wdata", last_wdata, 32'h0000_1234);
    chk("t2_no_timeout", n_to, 0);
    chk("t2_wr_count", wr_count, 32'd2);

    // Full held: timeout after exactly MAXR full cycles
    clr_mon();
    wfull = 1'b1;
    send(32'hAAAA_0003, 1'b0, ERR_NONE);
    wait_resp("t3_resp", 30);
    chk("t3_status", resp_status, WR_TIMEOUT);
    @(negedge wclk);
    chk("t3_full_evts", n_full, 10);
    chk("t3_timeout_cnt", n_to, 1);
    chk("t3_timeout_on_10th", full_at_to, 10);
    chk("t3_no_winc", n_winc, 0);
    chk("t3_wr_count", wr_count, 32'd2);

    // Overflow injection while full
    clr_mon();
    send(32'h5A5A5A5A, 1'b1, OVERFLOW);
    chk("t4_winc", winc, 1'b1);
    chk("t4_wdata", wdata, 32'h5A5A5A5A);
    chk("t4_ovf_evt", ovf_evt, 1'b1);
    @(negedge wclk);
    chk("t4_resp_valid", resp_valid, 1'b1);
    chk("t4_status", resp_status, WR_OVF_INJ);
    chk("t4_wr_count", wr_count, 32'd3);
    @(negedge wclk);
    chk("t4_no_full_evt", n_full, 0);
    chk("t4_ovf_cnt", n_ovf, 1);
    wfull = 1'b0;

    // Non-overflow injection kind behaves as a normal write
    clr_mon();
    send(32'h00C0FFEE, 1'b1, UNDERFLOW);
    chk("t4b_via_check", winc, 1'b0);
    wait_resp("t4b_resp", 10);
    chk("t4b_status", resp_status, WR_OK);
    @(negedge wclk);
    chk("t4b_no_ovf", n_ovf, 0);
    chk("t4b_winc_cnt", n_winc, 1);
    chk("t4b_wr_count", wr_count, 32'd4);

    // Response back-pressure; a pending request waits for the handshake
    clr_mon();
    resp_ready = 1'b0;
    send(32'h11111111, 1'b0, ERR_NONE);
    wait_resp("t5_resp", 10);
    req_valid = 1'b1;
    req_data  = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", resp_valid, 1'b1);
      chk("t5_hold_status", resp_status, WR_OK);
      chk("t5_hold_req_ready", req_ready, 1'b0);
      @(negedge wclk);
    end
    chk("t5_single_winc", n_winc, 1);
    resp_ready = 1'b1;
    @(negedge wclk);
    chk("t5_after_hs_ready", req_ready, 1'b1);
    chk("t5_after_hs_valid", resp_valid, 1'b0);
    @(negedge wclk);
    req_valid = 1'b0;
    wait_resp("t5_resp2", 10);
    chk("t5_status2", resp_status, WR_OK);
    @(negedge wclk);
    chk("t5_winc_cnt", n_winc, 2);
    chk("t5_wdata2", last_wdata, 32'h22222222);
    chk("t5_wr_count", wr_count, 32'd6);

    // Reset during CHECK
    wfull = 1'b1;
    send(32'h33333333, 1'b0, ERR_NONE);
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    chk("t6a_winc", winc, 1'b0);
    chk("t6a_resp_valid", resp_valid, 1'b0);
    chk("t6a_wr_count", wr_count, 32'd0);
    chk("t6a_req_ready", req_ready, 1'b1);
    @(negedge wclk);
    wrst_n = 1'b1;
    wfull  = 1'b0;
    @(negedge wclk);
    chk("t6a_no_resp", resp_valid, 1'b0);

    // Reset during ISSUE
    send(32'h44444444, 1'b0, ERR_NONE);
    @(negedge wclk);
    chk("t6b_issue_winc", winc, 1'b1);
    wrst_n = 1'b0;
    #1;
    chk("t6b_winc", winc, 1'b0);
    chk("t6b_wr_count", wr_count, 32'd0);
    chk("t6b_resp_valid", resp_valid, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    chk("t6b_no_resp", resp_valid, 1'b0);

    // Normal write after reset recovery
    clr_mon();
    send(32'hCAFEF00D, 1'b0, ERR_NONE);
    wait_resp("t6c_resp", 10);
    chk("t6c_status", resp_status, WR_OK);
    @(negedge wclk);
    chk("t6c_winc_cnt", n_winc, 1);
    chk("t6c_wdata", last_wdata, 32'hCAFEF00D);
    chk("t6c_wr_count", wr_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
